// File: rtl/vector_checker.sv
// Checks a stream of DUT results against a preloaded store of expected vectors.
// Counts mismatches, records the first failing index and reports pass/fail on done.
module vector_checker #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_valid,
   input  logic [WIDTH-1:0]         load_data,
   output logic                     load_ready,
   input  logic                     start,
   input  logic                     clear,
   input  logic                     res_valid,
   input  logic [WIDTH-1:0]         res_data,
   output logic                     res_ready,
   output logic [$clog2(DEPTH):0]   vec_count,
   output logic                     done,
   output logic                     pass,
   output logic [CNT_W-1:0]         err_count,
   output logic [$clog2(DEPTH)-1:0] first_err_idx,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic             load_fire;
   logic             res_fire;
   logic             mismatch;
   logic             last;
   logic [CW-1:0]    cnt_next;
   logic [CNT_W-1:0] err_next;

   // The write pointer is the low bits of vec_count; both advance together.
   always_comb begin
      load_fire = (state == IDLE) && load_valid && load_ready && !clear;
      res_fire  = (state == CHECK) && res_valid && res_ready && !clear;
      cnt_next  = vec_count + CW'(load_fire);
      mismatch  = res_data != mem[rd_ptr];
      last      = {1'b0, rd_ptr} == (vec_count - CW'(1));
      err_next  = (mismatch && (err_count != '1)) ? err_count + CNT_W'(1) : err_count;
   end

   always_ff @(posedge clk) begin
      if (load_fire)
         mem[vec_count[AW-1:0]] <= load_data;
   end

   // Ready flags are registered, so each transition also sets their next value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         vec_count     <= '0;
         rd_ptr        <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         overflow      <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         load_ready    <= 1'b1;
         res_ready     <= 1'b0;
      end else if (clear) begin
         state         <= IDLE;
         vec_count     <= '0;
         rd_ptr        <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         overflow      <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         load_ready    <= 1'b1;
         res_ready     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_fire)
                  vec_count <= cnt_next;
               if (load_valid && !load_ready)
                  overflow <= 1'b1;
               if (start) begin
                  rd_ptr        <= '0;
                  err_count     <= '0;
                  first_err_idx <= '0;
                  load_ready    <= 1'b0;
                  if (cnt_next != '0) begin
                     state     <= CHECK;
                     res_ready <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     pass  <= 1'b0;
                  end
               end else begin
                  load_ready <= cnt_next < FULL;
               end
            end
            CHECK: begin
               if (res_fire) begin
                  rd_ptr    <= rd_ptr + AW'(1);
                  err_count <= err_next;
                  if (mismatch && (err_count == '0))
                     first_err_idx <= rd_ptr;
                  if (last) begin
                     state     <= DONE;
                     res_ready <= 1'b0;
                     done      <= 1'b1;
                     pass      <= (err_next == '0);
                  end
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
